// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding-select
// values consumed in EX and the controller FSM states.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_LS = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LDUSE    = 2'd1,
    HZ_MDU_WAIT = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Busy-bit array for outstanding MDU destinations with two read ports.
// A set and a clear of the same register in one cycle leaves the bit set.
module hz_scoreboard #(
  parameter int NREG  = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd1_idx,
  input  logic [IDX_W-1:0] rd2_idx,
  output logic             rd1_busy,
  output logic             rd2_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    set_vec[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  assign rd1_busy = busy_q[rd1_idx];
  assign rd2_busy = busy_q[rd2_idx];

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard/forwarding controller for the IF/ID/EX/LS/WB pipeline:
// load-use and MDU stalls, redirect flush, memory freeze, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rs1_idx_id,
  input  logic [IDX_W-1:0] rs2_idx_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [IDX_W-1:0] rd_idx_ex,
  input  logic             wben_ex,
  input  logic             is_load_ex,
  input  logic [IDX_W-1:0] rd_idx_ls,
  input  logic             wben_ls,
  input  logic [IDX_W-1:0] rd_idx_wb,
  input  logic             wben_wb,
  input  logic             is_jump_ex,
  input  logic             mdu_issue_ex,
  input  logic [IDX_W-1:0] mdu_rd_ex,
  input  logic             mdu_done,
  input  logic [IDX_W-1:0] mdu_done_rd,
  input  logic             mem_busy_ls,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze_back,
  output logic [1:0]       rs1_fwd_sel,
  output logic [1:0]       rs2_fwd_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  if (IDX_W != $clog2(NREG) || XLEN < 32) begin : g_cfg_err
    $error("hazard_ctrl: IDX_W must equal clog2(NREG) and XLEN must be >= 32");
  end

  // WB-stage results reach EX through the regfile write-through, so the
  // WB destination is not a forwarding source here.
  logic wb_unused;
  assign wb_unused = ^{wben_wb, rd_idx_wb};

  function automatic logic hit(input logic used, input logic [IDX_W-1:0] src,
                               input logic en, input logic [IDX_W-1:0] rd);
    return used & en & (src == rd) & (rd != '0);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic used, input logic [IDX_W-1:0] src);
    if (hit(used, src, wben_ex & ~is_load_ex, rd_idx_ex)) return FWD_LS;
    if (hit(used, src, wben_ls, rd_idx_ls))               return FWD_WB;
    return FWD_RF;
  endfunction

  hz_state_e state_q, state_d;
  logic      sb1_busy, sb2_busy;
  logic      load_use, mdu_hz;

  hz_scoreboard #(.NREG(NREG), .IDX_W(IDX_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (mdu_issue_ex & (mdu_rd_ex != '0)),
    .set_idx  (mdu_rd_ex),
    .clr_en   (mdu_done),
    .clr_idx  (mdu_done_rd),
    .rd1_idx  (rs1_idx_id),
    .rd2_idx  (rs2_idx_id),
    .rd1_busy (sb1_busy),
    .rd2_busy (sb2_busy)
  );

  assign load_use = hit(rs1_used_id, rs1_idx_id, wben_ex & is_load_ex, rd_idx_ex)
                  | hit(rs2_used_id, rs2_idx_id, wben_ex & is_load_ex, rd_idx_ex);

  // An op issuing this cycle is not yet in the scoreboard, so match it directly.
  assign mdu_hz = (rs1_used_id & sb1_busy) | (rs2_used_id & sb2_busy)
                | hit(rs1_used_id, rs1_idx_id, mdu_issue_ex, mdu_rd_ex)
                | hit(rs2_used_id, rs2_idx_id, mdu_issue_ex, mdu_rd_ex);

  always_comb begin
    state_d     = state_q;
    stall_pc    = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;
    bubble_ex   = 1'b0;
    freeze_back = 1'b0;
    if (!rst_n) begin
      state_d = HZ_RUN;
    end else if (mem_busy_ls) begin
      freeze_back = 1'b1;
      stall_pc    = 1'b1;
      stall_id    = 1'b1;
      state_d     = HZ_MEM_WAIT;
    end else if (is_jump_ex) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      state_d   = HZ_RUN;
    end else if (state_q == HZ_LDUSE) begin
      // Load has moved to LS; the stalled reader proceeds and picks it up via WB.
      state_d = HZ_RUN;
    end else if (mdu_hz) begin
      stall_pc  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      state_d   = HZ_MDU_WAIT;
    end else if (load_use) begin
      stall_pc  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      state_d   = HZ_LDUSE;
    end else begin
      state_d = HZ_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HZ_RUN;
      rs1_fwd_sel  <= FWD_RF;
      rs2_fwd_sel  <= FWD_RF;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q      <= state_d;
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, stall_pc};
      flush_count  <= flush_count + {{(CNT_W-1){1'b0}}, flush_id};
      if (bubble_ex) begin
        rs1_fwd_sel <= FWD_RF;
        rs2_fwd_sel <= FWD_RF;
      end else if (!freeze_back) begin
        rs1_fwd_sel <= fwd_pick(rs1_used_id, rs1_idx_id);
        rs2_fwd_sel <= fwd_pick(rs2_used_id, rs2_idx_id);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected controls are queued as each step
// is driven and popped when the DUT outputs for that step are sampled.
module tb_hazard_ctrl;

  localparam int IDX_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IDX_W-1:0] rs1_idx_id, rs2_idx_id, rd_idx_ex, rd_idx_ls, rd_idx_wb, mdu_rd_ex, mdu_done_rd;
  logic             rs1_used_id, rs2_used_id, wben_ex, is_load_ex, wben_ls, wben_wb;
  logic             is_jump_ex, mdu_issue_ex, mdu_done, mem_busy_ls;
  logic             stall_pc, stall_id, flush_id, bubble_ex, freeze_back;
  logic [1:0]       rs1_fwd_sel, rs2_fwd_sel;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.XLEN(64), .NREG(32), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_idx_id(rs1_idx_id), .rs2_idx_id(rs2_idx_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_idx_ex(rd_idx_ex), .wben_ex(wben_ex), .is_load_ex(is_load_ex),
    .rd_idx_ls(rd_idx_ls), .wben_ls(wben_ls),
    .rd_idx_wb(rd_idx_wb), .wben_wb(wben_wb),
    .is_jump_ex(is_jump_ex), .mdu_issue_ex(mdu_issue_ex), .mdu_rd_ex(mdu_rd_ex),
    .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd), .mem_busy_ls(mem_busy_ls),
    .stall_pc(stall_pc), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .freeze_back(freeze_back),
    .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sp, sid, fid, bex, fb;
    logic [1:0] s1, s2;
  } exp_t;

  exp_t             q[$];
  int               total = 0;
  int               bad   = 0;
  string            step;
  logic [CNT_W-1:0] sc_m, fc_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s: got=%0h exp=%0h", step, tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rst_n = 1'b1;
    rs1_idx_id = '0; rs2_idx_id = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    rd_idx_ex = '0; wben_ex = 1'b0; is_load_ex = 1'b0;
    rd_idx_ls = '0; wben_ls = 1'b0; rd_idx_wb = '0; wben_wb = 1'b0;
    is_jump_ex = 1'b0; mdu_issue_ex = 1'b0; mdu_rd_ex = '0;
    mdu_done = 1'b0; mdu_done_rd = '0; mem_busy_ls = 1'b0;
  endtask

  // One pipeline cycle: inputs already driven; combinational controls are
  // checked mid-cycle, registered selects and counters just after the edge.
  task automatic cyc(input logic sp, input logic sid, input logic fid, input logic bex,
                     input logic fb, input logic [1:0] s1, input logic [1:0] s2);
    exp_t e;
    e = '{sp: sp, sid: sid, fid: fid, bex: bex, fb: fb, s1: s1, s2: s2};
    q.push_back(e);
    #2;
    e = q.pop_front();
    chk("stall_pc",    32'(stall_pc),    32'(e.sp));
    chk("stall_id",    32'(stall_id),    32'(e.sid));
    chk("flush_id",    32'(flush_id),    32'(e.fid));
    chk("bubble_ex",   32'(bubble_ex),   32'(e.bex));
    chk("freeze_back", 32'(freeze_back), 32'(e.fb));
    if (!rst_n) begin
      sc_m = '0;
      fc_m = '0;
    end else begin
      sc_m = sc_m + CNT_W'(e.sp);
      fc_m = fc_m + CNT_W'(e.fid);
    end
    @(posedge clk);
    #1;
    chk("rs1_fwd_sel",  32'(rs1_fwd_sel), 32'(e.s1));
    chk("rs2_fwd_sel",  32'(rs2_fwd_sel), 32'(e.s2));
    chk("stall_cycles", stall_cycles,     sc_m);
    chk("flush_count",  flush_count,      fc_m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    sc_m = '0; fc_m = '0;
    clr_in();
    rst_n = 1'b0;
    step = "reset0"; cyc(0,0,0,0,0, 2'd0, 2'd0);
    // Hazard inputs active during reset must not raise any control.
    rd_idx_ex = 5'd5; wben_ex = 1'b1; is_load_ex = 1'b1;
    rs1_idx_id = 5'd5; rs1_used_id = 1'b1; mem_busy_ls = 1'b1; is_jump_ex = 1'b1;
    step = "reset1"; cyc(0,0,0,0,0, 2'd0, 2'd0);

    // Load-use on x5: one stall cycle, then WB forwarding.
    clr_in();
    rd_idx_ex = 5'd5; wben_ex = 1'b1; is_load_ex = 1'b1; rs1_idx_id = 5'd5; rs1_used_id = 1'b1;
    step = "ld_use"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    rd_idx_ex = '0; wben_ex = 1'b0; is_load_ex = 1'b0; rd_idx_ls = 5'd5; wben_ls = 1'b1;
    step = "ld_fwd"; cyc(0,0,0,0,0, 2'd2, 2'd0);

    // x0 producers never match.
    clr_in();
    wben_ex = 1'b1; rs1_used_id = 1'b1;
    step = "x0_alu"; cyc(0,0,0,0,0, 2'd0, 2'd0);
    is_load_ex = 1'b1;
    step = "x0_ld"; cyc(0,0,0,0,0, 2'd0, 2'd0);

    // Closest producer wins; freeze holds the selects.
    clr_in();
    rd_idx_ex = 5'd3; wben_ex = 1'b1; rd_idx_ls = 5'd3; wben_ls = 1'b1;
    rs1_idx_id = 5'd3; rs2_idx_id = 5'd3; rs2_used_id = 1'b1;
    step = "fwd_ex"; cyc(0,0,0,0,0, 2'd0, 2'd1);
    wben_ex = 1'b0;
    step = "fwd_ls"; cyc(0,0,0,0,0, 2'd0, 2'd2);
    wben_ex = 1'b1; mem_busy_ls = 1'b1;
    step = "frz_hold"; cyc(1,1,0,0,1, 2'd0, 2'd2);
    is_jump_ex = 1'b1;
    step = "frz_jump"; cyc(1,1,0,0,1, 2'd0, 2'd2);
    is_jump_ex = 1'b0; mem_busy_ls = 1'b0;
    step = "frz_exit"; cyc(0,0,0,0,0, 2'd0, 2'd1);

    // Redirect discards a same-cycle load-use; FSM stays in RUN.
    clr_in();
    rd_idx_ex = 5'd6; wben_ex = 1'b1; is_load_ex = 1'b1; rs2_idx_id = 5'd6; rs2_used_id = 1'b1;
    is_jump_ex = 1'b1;
    step = "jmp_lduse"; cyc(0,0,1,1,0, 2'd0, 2'd0);
    is_jump_ex = 1'b0;
    step = "post_jmp"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    clr_in();
    step = "after_ld2"; cyc(0,0,0,0,0, 2'd0, 2'd0);

    // MDU stall on x7 with a memory freeze in the middle.
    mdu_issue_ex = 1'b1; mdu_rd_ex = 5'd7; rs1_idx_id = 5'd7; rs1_used_id = 1'b1;
    step = "mdu_issue"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mdu_issue_ex = 1'b0;
    step = "mdu_wait"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mem_busy_ls = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step = $sformatf("mem_frz%0d", i); cyc(1,1,0,0,1, 2'd0, 2'd0);
    end
    mem_busy_ls = 1'b0;
    step = "mdu_resume"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mdu_done = 1'b1; mdu_done_rd = 5'd7;
    step = "mdu_done"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mdu_done = 1'b0; rd_idx_ls = 5'd7; wben_ls = 1'b1;
    step = "mdu_clear"; cyc(0,0,0,0,0, 2'd2, 2'd0);

    // Same-cycle issue and completion of x7: bit stays set.
    clr_in();
    mdu_issue_ex = 1'b1; mdu_rd_ex = 5'd7;
    step = "sb_issue"; cyc(0,0,0,0,0, 2'd0, 2'd0);
    mdu_done = 1'b1; mdu_done_rd = 5'd7;
    step = "sb_same"; cyc(0,0,0,0,0, 2'd0, 2'd0);
    clr_in();
    rs2_idx_id = 5'd7; rs2_used_id = 1'b1;
    step = "sb_kept"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mdu_done = 1'b1; mdu_done_rd = 5'd7;
    step = "sb_done"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mdu_done = 1'b0;
    step = "sb_free"; cyc(0,0,0,0,0, 2'd0, 2'd0);

    // MDU writing x0 never blocks.
    clr_in();
    mdu_issue_ex = 1'b1; rs1_used_id = 1'b1;
    step = "mdu_x0"; cyc(0,0,0,0,0, 2'd0, 2'd0);
    mdu_issue_ex = 1'b0;
    step = "x0_sb"; cyc(0,0,0,0,0, 2'd0, 2'd0);

    // Reset while in MDU_WAIT clears scoreboard, counters and selects.
    clr_in();
    mdu_issue_ex = 1'b1; mdu_rd_ex = 5'd9; rs2_idx_id = 5'd9; rs2_used_id = 1'b1;
    step = "rst_mdu"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    mdu_issue_ex = 1'b0; rd_idx_ls = 5'd9; wben_ls = 1'b1;
    step = "rst_wait"; cyc(1,1,0,1,0, 2'd0, 2'd0);
    rst_n = 1'b0;
    step = "rst_mid"; cyc(0,0,0,0,0, 2'd0, 2'd0);
    rst_n = 1'b1;
    step = "rst_after"; cyc(0,0,0,0,0, 2'd0, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Centralised hazard and forwarding controller for the 5-stage RV64 pipeline (IF/ID/EX/LS/WB).
- Generalises the current forwarding unit with the following additions:
  - load-use stall with bubble insertion
  - branch/jump redirect flush
  - scoreboard for a variable-latency multiply/divide unit (MDU)
  - whole-pipe freeze while LS memory is busy
  - performance counters
- Drives stall/flush/bubble controls of PC_reg, ID_reg, EX_reg, L_S_reg and WB_reg, plus registered forwarding selects consumed in EX.

Parameters:
- XLEN, 64, datapath width (forwarded data only passes through the datapath; used for consistency checks).
- NREG, 32, architectural register count; scoreboard depth.
- IDX_W, 5, register index width; must equal clog2(NREG).
- CNT_W, 32, performance counter width.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous active-low reset.
- rs1_idx_id in IDX_W: rs1 index of the instruction in ID.
- rs2_idx_id in IDX_W: rs2 index of the instruction in ID.
- rs1_used_id in 1: the ID instruction reads rs1.
- rs2_used_id in 1: the ID instruction reads rs2.
- rd_idx_ex in IDX_W, wben_ex in 1, is_load_ex in 1: destination, write enable and load flag of the instruction in EX.
- rd_idx_ls in IDX_W, wben_ls in 1: destination and write enable of the instruction in LS.
- rd_idx_wb in IDX_W, wben_wb in 1: destination and write enable of the instruction in WB.
- is_jump_ex in 1: EX resolved a taken branch, jal or jalr.
- mdu_issue_ex in 1: MDU op accepted in EX this cycle.
- mdu_rd_ex in IDX_W: destination of the MDU op being issued.
- mdu_done in 1: MDU result written back this cycle.
- mdu_done_rd in IDX_W: destination of the completing MDU op.
- mem_busy_ls in 1: LS memory access not yet complete.
- stall_pc out 1: hold PC_reg.
- stall_id out 1: hold ID_reg.
- flush_id out 1: load NOP into ID_reg.
- bubble_ex out 1: load NOP into EX_reg (wben=0, is_jump=0).
- freeze_back out 1: hold EX_reg, L_S_reg and WB_reg.
- rs1_fwd_sel out 2: registered EX operand-1 source. 0 = regfile, 1 = LS alu result, 2 = WB data.
- rs2_fwd_sel out 2: same encoding for operand 2.
- stall_cycles out CNT_W: count of cycles with stall_pc=1.
- flush_count out CNT_W: count of redirects.

Behaviour:
Reset (rst_n=0 at posedge):
- FSM enters RUN.
- Scoreboard cleared.
- Both fwd_sel = 0; both counters = 0.
- Combinational outputs in reset cycle: all controls 0.

Hazard terms (evaluated combinationally in ID):
- An index of 0 never matches anything.
- match(x, rd, en) = used_x & en & (idx_x == rd) & (rd != 0).
- load_use = match(rs1/rs2, rd_idx_ex, wben_ex & is_load_ex).
- mdu_hz = any used source whose scoreboard bit is set, or that matches mdu_rd_ex while mdu_issue_ex=1.

FSM states: RUN, LDUSE, MDU_WAIT, MEM_WAIT. Priority each cycle: mem_busy_ls > is_jump_ex > mdu_hz > load_use.
- Any state with mem_busy_ls=1 → MEM_WAIT.
  - freeze_back=1, stall_pc=1, stall_id=1; all other controls 0; fwd_sel held.
  - Leaves to RUN on the first cycle mem_busy_ls=0; that cycle is evaluated normally.
- is_jump_ex=1 (not mem-busy):
  - flush_id=1, bubble_ex=1, stall_pc=0; flush_count += 1; state → RUN.
  - A pending load-use or MDU stall is discarded.
- mdu_hz (RUN or MDU_WAIT):
  - stall_pc=1, stall_id=1, bubble_ex=1; state MDU_WAIT.
  - Returns to RUN the cycle after the blocking scoreboard bit clears.
- load_use in RUN:
  - stall_pc=1, stall_id=1, bubble_ex=1 for exactly one cycle; state LDUSE.
  - LDUSE → RUN unconditionally next cycle. The load is then in LS, so forwarding uses source 2 one cycle later via WB.

Forwarding selects:
- Registered at posedge whenever EX_reg loads, i.e. not freeze_back and not bubble_ex.
- Closest producer wins: LS-bound (current EX: rd_idx_ex, wben_ex, not load) → 1; else LS-stage match → 2; else 0.
- On bubble_ex the selects are cleared to 0.

Scoreboard:
- Bit rd set on mdu_issue_ex (rd != 0); cleared on mdu_done.
- Set and clear of the same index in the same cycle: set wins.
- Bit 0 is constant 0.

Counters:
- Wrap modulo 2^CNT_W.
- Not reset by flush; only rst_n clears them.

Decomposition:
- Shared package: fwd_sel encoding constants (FWD_RF, FWD_LS, FWD_WB) and the FSM state enum (HZ_RUN, HZ_LDUSE, HZ_MDU_WAIT, HZ_MEM_WAIT), both added to defines.v.
- One sub-module: hz_scoreboard (NREG-bit set/clear array plus lookup of two sources). Everything else stays in hazard_ctrl.

Test Plan:
- Load-use: ld x5 in EX (is_load_ex=1, wben_ex=1, rd=5), add reading x5 in ID → one cycle of stall_pc=stall_id=bubble_ex=1, then rs1_fwd_sel=2 when the add enters EX; stall_cycles=1.
- x0 producer: rd_idx_ex=0, wben_ex=1, rs1_idx_id=0 → no stall, rs1_fwd_sel=0.
- Redirect during load-use: is_jump_ex=1 in the same cycle as load_use → flush_id=1, bubble_ex=1, stall_pc=0, state RUN, flush_count=1.
- MDU: issue div to x7, then a reader of x7 arrives in ID → stalls until mdu_done with mdu_done_rd=7; the reader enters EX the cycle after. A same-cycle issue of x7 together with completion of an old x7 keeps the bit set.
- Memory freeze: mem_busy_ls=1 for 3 cycles during an MDU stall → freeze_back=1 for 3 cycles, fwd_sel unchanged, then MDU_WAIT resumes.
- Reset mid-stall: rst_n=0 while in MDU_WAIT → next cycle state RUN, scoreboard empty, counters 0, fwd_sel 0.
